ser_xmt_arb: RTL and testbench

- Shares one serial transmitter (load/empty/8-bit byte interface) between NUM_REQ byte-stream requesters.
- Round-robin arbitration, with an optional per-requester lock so a multi-byte message is sent without interleaving.
- Sequences the transmitter's load/empty handshake and flags a transmitter that never starts.
- Sits between the console/debug byte sources and the UART transmit path.

---
 rtl/ser_xmt_arb.sv | 128 ++++++++++++
 tb/tb_ser_xmt_arb.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/ser_xmt_arb.sv
// Round-robin arbiter sharing one load/empty byte transmitter between NUM_REQ
// requesters, with per-requester grant lock and a sticky start-timeout flag.
module ser_xmt_arb #(
    parameter int NUM_REQ       = 4,
    parameter int IDW           = 2,
    parameter int START_TIMEOUT = 15
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [NUM_REQ-1:0]   lock,
    input  logic [8*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   ack,
    output logic                 xmt_load,
    output logic [7:0]           xmt_data,
    input  logic                 xmt_empty,
    output logic                 busy,
    output logic [IDW-1:0]       grant_id,
    output logic                 err
);

    // Handshake: req[i] holds with stable req_data until a one-cycle ack[i];
    // xmt_load is a one-cycle strobe, xmt_empty low means the transmitter started.
    typedef enum logic [1:0] {IDLE, LOAD, WAIT_START, WAIT_DONE} state_t;

    state_t               state_q, state_d;
    logic [IDW-1:0]       last_q, last_d;
    logic [NUM_REQ-1:0]   ack_q, ack_d;
    logic                 load_q, load_d;
    logic [7:0]           data_q, data_d;
    logic                 busy_q, busy_d;
    logic [7:0]           cnt_q, cnt_d;
    logic                 err_q, err_d;

    logic [IDW-1:0]       win;
    logic                 win_found;
    logic [IDW-1:0]       idx;

    // A locked owner with a pending byte keeps the grant; otherwise search
    // starts after the last owner so the last owner is considered last.
    always_comb begin
        win       = last_q;
        win_found = 1'b0;
        idx       = '0;
        if (lock[last_q] && req[last_q]) begin
            win_found = 1'b1;
        end else begin
            for (int i = 1; i <= NUM_REQ; i++) begin
                idx = IDW'((int'(last_q) + i) % NUM_REQ);
                if (!win_found && req[idx]) begin
                    win       = idx;
                    win_found = 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        ack_d   = '0;
        load_d  = 1'b0;
        data_d  = data_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (xmt_empty && win_found) begin
                    data_d     = req_data[{win, 3'b000} +: 8];
                    last_d     = win;
                    ack_d[win] = 1'b1;
                    load_d     = 1'b1;
                    state_d    = LOAD;
                end
            end
            LOAD: begin
                cnt_d   = 8'd0;
                state_d = WAIT_START;
            end
            WAIT_START: begin
                if (!xmt_empty) begin
                    state_d = WAIT_DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_d == 8'(START_TIMEOUT)) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            WAIT_DONE: begin
                if (xmt_empty) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            last_q  <= IDW'(NUM_REQ - 1);
            ack_q   <= '0;
            load_q  <= 1'b0;
            data_q  <= 8'h00;
            busy_q  <= 1'b0;
            cnt_q   <= 8'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            ack_q   <= ack_d;
            load_q  <= load_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign ack      = ack_q;
    assign xmt_load = load_q;
    assign xmt_data = data_q;
    assign busy     = busy_q;
    assign grant_id = last_q;
    assign err      = err_q;

endmodule

// File: tb/tb_ser_xmt_arb.sv
// Directed bench for ser_xmt_arb: reset, basic frame, round-robin, lock,
// start timeout, mid-frame reset and request-while-busy scenarios.
module tb_ser_xmt_arb;

    localparam int NUM_REQ = 4;
    localparam int IDW     = 2;
    localparam int TMO     = 15;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic [NUM_REQ-1:0]   req = '0;
    logic [NUM_REQ-1:0]   lock = '0;
    logic [8*NUM_REQ-1:0] req_data = '0;
    logic [NUM_REQ-1:0]   ack;
    logic                 xmt_load;
    logic [7:0]           xmt_data;
    logic                 xmt_empty = 1'b1;
    logic                 busy;
    logic [IDW-1:0]       grant_id;
    logic                 err;

    int n_vec = 0;
    int n_err = 0;

    ser_xmt_arb #(.NUM_REQ(NUM_REQ), .IDW(IDW), .START_TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .req(req), .lock(lock), .req_data(req_data),
        .ack(ack), .xmt_load(xmt_load), .xmt_data(xmt_data), .xmt_empty(xmt_empty),
        .busy(busy), .grant_id(grant_id), .err(err)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1; req = '0; lock = '0; xmt_empty = 1'b1;
        tick(); tick();
        reset = 1'b0;
    endtask

    // Waits (bounded) for a load, captures it, then models a transmitter that
    // drops empty one cycle after the load and stays busy for 'hold' more cycles.
    task automatic do_frame(input int hold, output int lat, output logic [IDW-1:0] gid,
                            output logic [7:0] gdat, output logic [NUM_REQ-1:0] gack,
                            output int stray);
        lat = -1; gid = '0; gdat = '0; gack = '0; stray = 0;
        for (int i = 1; i <= 10 && lat < 0; i++) begin
            tick();
            if (xmt_load === 1'b1) begin
                lat = i; gid = grant_id; gdat = xmt_data; gack = ack;
            end
        end
        if (lat < 0) return;
        xmt_empty = 1'b0;
        tick();
        if (ack !== '0 || xmt_load !== 1'b0) stray++;
        repeat (hold) begin
            tick();
            if (ack !== '0 || xmt_load !== 1'b0) stray++;
        end
        xmt_empty = 1'b1;
        tick();
        if (ack !== '0 || xmt_load !== 1'b0) stray++;
    endtask

    task automatic test_reset();
        apply_reset();
        n_vec++; if (ack !== 4'b0000) begin n_err++; $display("FAIL rst_ack got=%b exp=0000", ack); end
        n_vec++; if (xmt_load !== 1'b0) begin n_err++; $display("FAIL rst_load got=%b exp=0", xmt_load); end
        n_vec++; if (xmt_data !== 8'h00) begin n_err++; $display("FAIL rst_data got=%h exp=00", xmt_data); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy got=%b exp=0", busy); end
        n_vec++; if (grant_id !== 2'd3) begin n_err++; $display("FAIL rst_gid got=%0d exp=3", grant_id); end
        n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL rst_err got=%b exp=0", err); end
    endtask

    task automatic test_basic();
        int nb;
        apply_reset();
        req = 4'b0001; req_data[7:0] = 8'h41; xmt_empty = 1'b1;
        tick();
        n_vec++; if (ack !== 4'b0001) begin n_err++; $display("FAIL basic_ack got=%b exp=0001", ack); end
        n_vec++; if (xmt_load !== 1'b1) begin n_err++; $display("FAIL basic_load got=%b exp=1", xmt_load); end
        n_vec++; if (xmt_data !== 8'h41) begin n_err++; $display("FAIL basic_data got=%h exp=41", xmt_data); end
        n_vec++; if (grant_id !== 2'd0) begin n_err++; $display("FAIL basic_gid got=%0d exp=0", grant_id); end
        req = 4'b0000; req_data[7:0] = 8'hFF; xmt_empty = 1'b0;
        tick();
        n_vec++; if (ack !== 4'b0000 || xmt_load !== 1'b0)
            begin n_err++; $display("FAIL basic_pulse got ack=%b load=%b exp 0000/0", ack, xmt_load); end
        nb = 0;
        repeat (20) begin tick(); if (busy !== 1'b1) nb++; end
        n_vec++; if (nb !== 0) begin n_err++; $display("FAIL basic_busy_hold got=%0d idle cycles exp=0", nb); end
        xmt_empty = 1'b1;
        tick();
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL basic_busy_drop got=%b exp=0", busy); end
        n_vec++; if (xmt_data !== 8'h41) begin n_err++; $display("FAIL basic_data_hold got=%h exp=41", xmt_data); end
    endtask

    task automatic test_round_robin();
        int lat, stray;
        logic [IDW-1:0] gid;
        logic [7:0] gdat;
        logic [NUM_REQ-1:0] gack;
        logic [IDW-1:0] exp_id;
        logic [7:0] exp_dat;
        logic [NUM_REQ-1:0] exp_ack;
        apply_reset();
        for (int i = 0; i < NUM_REQ; i++) req_data[8*i +: 8] = 8'hA0 + 8'(i);
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            exp_id  = IDW'(k % NUM_REQ);
            exp_dat = 8'hA0 + 8'(k % NUM_REQ);
            exp_ack = 4'b0001 << (k % NUM_REQ);
            do_frame(4, lat, gid, gdat, gack, stray);
            n_vec++; if (lat !== 1) begin n_err++; $display("FAIL rr_lat[%0d] got=%0d exp=1", k, lat); end
            n_vec++; if (gid !== exp_id || gdat !== exp_dat || gack !== exp_ack)
                begin n_err++; $display("FAIL rr_grant[%0d] got id=%0d d=%h ack=%b exp id=%0d d=%h ack=%b",
                                        k, gid, gdat, gack, exp_id, exp_dat, exp_ack); end
            n_vec++; if (stray !== 0) begin n_err++; $display("FAIL rr_busy_grant[%0d] got=%0d exp=0", k, stray); end
        end
        req = '0;
    endtask

    task automatic test_lock();
        int lat, stray;
        logic [IDW-1:0] gid;
        logic [7:0] gdat;
        logic [NUM_REQ-1:0] gack;
        apply_reset();
        req_data = {8'hD3, 8'hD2, 8'hD1, 8'hD0};
        req = 4'b0110; lock = 4'b0010;
        for (int k = 0; k < 3; k++) begin
            do_frame(2, lat, gid, gdat, gack, stray);
            n_vec++; if (gid !== 2'd1 || gdat !== 8'hD1 || lat !== 1)
                begin n_err++; $display("FAIL lock_hold[%0d] got id=%0d d=%h lat=%0d exp id=1 d=d1 lat=1", k, gid, gdat, lat); end
        end
        lock = 4'b0000;
        do_frame(2, lat, gid, gdat, gack, stray);
        n_vec++; if (gid !== 2'd2 || gack !== 4'b0100)
            begin n_err++; $display("FAIL lock_release got id=%0d ack=%b exp id=2 ack=0100", gid, gack); end
        // Owner 2 locks with no byte pending: requester 0 must still win.
        req = 4'b0001; lock = 4'b0100;
        do_frame(2, lat, gid, gdat, gack, stray);
        n_vec++; if (gid !== 2'd0 || gdat !== 8'hD0)
            begin n_err++; $display("FAIL lock_no_req got id=%0d d=%h exp id=0 d=d0", gid, gdat); end
        req = '0; lock = '0;
    endtask

    task automatic test_timeout();
        int lat, stray;
        logic [IDW-1:0] gid;
        logic [7:0] gdat;
        logic [NUM_REQ-1:0] gack;
        apply_reset();
        req = 4'b0001; req_data[7:0] = 8'h11; xmt_empty = 1'b1;
        tick();
        n_vec++; if (xmt_load !== 1'b1) begin n_err++; $display("FAIL tmo_load got=%b exp=1", xmt_load); end
        req = '0;
        tick();
        repeat (TMO - 1) tick();
        n_vec++; if (err !== 1'b0 || busy !== 1'b1)
            begin n_err++; $display("FAIL tmo_early got err=%b busy=%b exp err=0 busy=1", err, busy); end
        tick();
        n_vec++; if (err !== 1'b1 || busy !== 1'b0)
            begin n_err++; $display("FAIL tmo_fire got err=%b busy=%b exp err=1 busy=0", err, busy); end
        req = 4'b1000; req_data[31:24] = 8'h5A;
        do_frame(3, lat, gid, gdat, gack, stray);
        req = '0;
        n_vec++; if (gid !== 2'd3 || gdat !== 8'h5A || lat !== 1)
            begin n_err++; $display("FAIL tmo_next got id=%0d d=%h lat=%0d exp id=3 d=5a lat=1", gid, gdat, lat); end
        n_vec++; if (err !== 1'b1) begin n_err++; $display("FAIL tmo_sticky got=%b exp=1", err); end
    endtask

    task automatic test_reset_mid_frame();
        int lat, stray;
        logic [IDW-1:0] gid;
        logic [7:0] gdat;
        logic [NUM_REQ-1:0] gack;
        apply_reset();
        req = 4'b0100; req_data[23:16] = 8'h77;
        tick();
        req = '0; xmt_empty = 1'b0;
        tick(); tick(); tick();
        reset = 1'b1;
        tick();
        n_vec++; if (busy !== 1'b0 || ack !== 4'b0000 || xmt_load !== 1'b0 || grant_id !== 2'd3)
            begin n_err++; $display("FAIL midrst got busy=%b ack=%b load=%b id=%0d exp 0/0000/0/3",
                                    busy, ack, xmt_load, grant_id); end
        reset = 1'b0; xmt_empty = 1'b1;
        req = 4'b1001; req_data[7:0] = 8'h30; req_data[31:24] = 8'h33;
        do_frame(2, lat, gid, gdat, gack, stray);
        req = '0;
        n_vec++; if (gid !== 2'd0 || gdat !== 8'h30)
            begin n_err++; $display("FAIL midrst_first got id=%0d d=%h exp id=0 d=30", gid, gdat); end
    endtask

    task automatic test_back_to_back();
        int na;
        apply_reset();
        req = 4'b0001; req_data[7:0] = 8'h01;
        tick();
        req = '0; xmt_empty = 1'b0;
        tick(); tick();
        req = 4'b1000; req_data[31:24] = 8'hC3;
        na = 0;
        repeat (6) begin tick(); if (ack !== 4'b0000 || xmt_load !== 1'b0) na++; end
        n_vec++; if (na !== 0) begin n_err++; $display("FAIL busy_req_early got=%0d acks exp=0", na); end
        xmt_empty = 1'b1;
        tick();
        n_vec++; if (ack !== 4'b0000 || busy !== 1'b0)
            begin n_err++; $display("FAIL busy_req_idle got ack=%b busy=%b exp 0000/0", ack, busy); end
        tick();
        n_vec++; if (ack !== 4'b1000 || xmt_data !== 8'hC3 || xmt_load !== 1'b1)
            begin n_err++; $display("FAIL busy_req_ack got ack=%b d=%h load=%b exp 1000/c3/1", ack, xmt_data, xmt_load); end
        req = '0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_round_robin();
        test_lock();
        test_timeout();
        test_reset_mid_frame();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
